// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Producer side of the ALU operand/select interface. Takes RV32I instructions
// with their register-file read data over a valid/ready handshake, decodes
// ALU-class instructions (OP, OP-IMM, LUI, AUIPC) into an ALU select and two
// operands, and presents them through a registered output stage backed by a
// one-entry skid buffer. Non-ALU or malformed instructions are still issued,
// flagged with op_illegal and select INVALID.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   flush        synchronous clear of output register and skid buffer
//   instr_valid  upstream instruction valid
//   instr_ready  stage can accept (registered, no path from op_ready)
//   instr        RV32I instruction word
//   pc           address of instr
//   rs1_data     register-file value for instr[19:15]
//   rs2_data     register-file value for instr[24:20]
//   op_valid     ALU operation presented
//   op_ready     downstream consumes the operation this cycle
//   op_a, op_b   ALU operands
//   op_sel       ALU select (ADD=0 .. SRA=9, NOP=10, INVALID=15)
//   op_rd        destination register
//   op_illegal   instruction was not ALU-class or was malformed
//
// Optional build macro ALU_ISSUE_STATS_EN adds:
//   issued_count   32-bit count of transfers
//   illegal_count  16-bit saturating count of transfers with op_illegal=1
// ---------------------------------------------------------------------------
module alu_issue_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [XLEN-1:0] instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            op_valid,
   input  logic            op_ready,
   output logic [XLEN-1:0] op_a,
   output logic [XLEN-1:0] op_b,
   output logic [3:0]      op_sel,
   output logic [4:0]      op_rd,
   output logic            op_illegal
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [31:0]     issued_count,
   output logic [15:0]     illegal_count
`endif
);

   localparam logic [3:0] SEL_ADD     = 4'd0;
   localparam logic [3:0] SEL_SUB     = 4'd1;
   localparam logic [3:0] SEL_AND     = 4'd2;
   localparam logic [3:0] SEL_OR      = 4'd3;
   localparam logic [3:0] SEL_XOR     = 4'd4;
   localparam logic [3:0] SEL_SLT     = 4'd5;
   localparam logic [3:0] SEL_SLTU    = 4'd6;
   localparam logic [3:0] SEL_SLL     = 4'd7;
   localparam logic [3:0] SEL_SRL     = 4'd8;
   localparam logic [3:0] SEL_SRA     = 4'd9;
   localparam logic [3:0] SEL_NOP     = 4'd10;
   localparam logic [3:0] SEL_INVALID = 4'd15;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [3:0]      sel;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [4:0]      rd;
      logic            illegal;
   } op_t;

   localparam op_t OP_RESET = '{sel: SEL_NOP, a: '0, b: '0, rd: '0, illegal: 1'b0};

   // Shared funct3 -> select map for OP and OP-IMM (funct7 base encoding).
   function automatic logic [3:0] f3_to_sel(input logic [2:0] f3);
      logic [3:0] s;
      case (f3)
         3'b000:  s = SEL_ADD;
         3'b001:  s = SEL_SLL;
         3'b010:  s = SEL_SLT;
         3'b011:  s = SEL_SLTU;
         3'b100:  s = SEL_XOR;
         3'b101:  s = SEL_SRL;
         3'b110:  s = SEL_OR;
         default: s = SEL_AND;
      endcase
      return s;
   endfunction

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [6:0]      w_funct7;
   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_u;
   logic [XLEN-1:0] w_shamt;

   assign w_opcode = instr[6:0];
   assign w_funct3 = instr[14:12];
   assign w_funct7 = instr[31:25];
   assign w_imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign w_imm_u  = {instr[XLEN-1:12], 12'b0};
   assign w_shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};

   logic            w_dec_legal;
   logic [3:0]      w_dec_sel;
   logic [XLEN-1:0] w_dec_a;
   logic [XLEN-1:0] w_dec_b;
   op_t             w_dec;

   always_comb begin
      w_dec_legal = 1'b0;
      w_dec_sel   = SEL_INVALID;
      w_dec_a     = '0;
      w_dec_b     = '0;
      case (w_opcode)
         OPC_OP: begin
            w_dec_a = rs1_data;
            w_dec_b = rs2_data;
            if (w_funct7 == F7_BASE) begin
               w_dec_legal = 1'b1;
               w_dec_sel   = f3_to_sel(w_funct3);
            end else if (w_funct7 == F7_ALT) begin
               if (w_funct3 == 3'b000) begin
                  w_dec_legal = 1'b1;
                  w_dec_sel   = SEL_SUB;
               end else if (w_funct3 == 3'b101) begin
                  w_dec_legal = 1'b1;
                  w_dec_sel   = SEL_SRA;
               end
            end
         end
         OPC_OP_IMM: begin
            w_dec_a = rs1_data;
            w_dec_b = w_imm_i;
            case (w_funct3)
               3'b001: begin
                  w_dec_b     = w_shamt;
                  w_dec_sel   = SEL_SLL;
                  w_dec_legal = (w_funct7 == F7_BASE);
               end
               3'b101: begin
                  w_dec_b = w_shamt;
                  if (w_funct7 == F7_BASE) begin
                     w_dec_legal = 1'b1;
                     w_dec_sel   = SEL_SRL;
                  end else if (w_funct7 == F7_ALT) begin
                     w_dec_legal = 1'b1;
                     w_dec_sel   = SEL_SRA;
                  end
               end
               default: begin
                  w_dec_legal = 1'b1;
                  w_dec_sel   = f3_to_sel(w_funct3);
               end
            endcase
         end
         OPC_LUI: begin
            w_dec_legal = 1'b1;
            w_dec_sel   = SEL_ADD;
            w_dec_b     = w_imm_u;
         end
         OPC_AUIPC: begin
            w_dec_legal = 1'b1;
            w_dec_sel   = SEL_ADD;
            w_dec_a     = pc;
            w_dec_b     = w_imm_u;
         end
         default: begin
         end
      endcase
   end

   // Anything not legal collapses to a clean INVALID record so partially
   // decoded operands never leak downstream.
   always_comb begin
      if (w_dec_legal) begin
         w_dec = '{sel: w_dec_sel, a: w_dec_a, b: w_dec_b, rd: instr[11:7], illegal: 1'b0};
      end else begin
         w_dec = '{sel: SEL_INVALID, a: '0, b: '0, rd: '0, illegal: 1'b1};
      end
   end

   op_t  r_out;
   logic r_out_valid;
   op_t  r_skid;
   logic r_skid_valid;

   logic w_accept;
   logic w_xfer;

   assign instr_ready = !r_skid_valid;
   assign w_accept    = instr_valid && instr_ready;
   assign w_xfer      = r_out_valid && op_ready;

   // Output register plus one-entry skid. The skid can only be occupied while
   // the output register is valid, and while it is occupied instr_ready is low,
   // so an accept never coincides with a skid-to-output move.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out        <= OP_RESET;
         r_out_valid  <= 1'b0;
         r_skid       <= OP_RESET;
         r_skid_valid <= 1'b0;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else begin
         if (!r_out_valid || w_xfer) begin
            if (r_skid_valid) begin
               r_out        <= r_skid;
               r_out_valid  <= 1'b1;
               r_skid_valid <= 1'b0;
            end else if (w_accept) begin
               r_out       <= w_dec;
               r_out_valid <= 1'b1;
            end else begin
               r_out_valid <= 1'b0;
            end
         end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
         end
      end
   end

   assign op_valid   = r_out_valid;
   assign op_a       = r_out.a;
   assign op_b       = r_out.b;
   assign op_sel     = r_out.sel;
   assign op_rd      = r_out.rd;
   assign op_illegal = r_out.illegal;

`ifdef ALU_ISSUE_STATS_EN
   logic [31:0] r_issued_count;
   logic [15:0] r_illegal_count;

   // Counters track real transfers, including one that lands in a flush cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_issued_count  <= '0;
         r_illegal_count <= '0;
      end else if (w_xfer) begin
         r_issued_count <= r_issued_count + 32'd1;
         if (r_out.illegal && (r_illegal_count != 16'hFFFF)) begin
            r_illegal_count <= r_illegal_count + 16'd1;
         end
      end
   end

   assign issued_count  = r_issued_count;
   assign illegal_count = r_illegal_count;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        op_valid;
   logic        op_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  op_sel;
   logic [4:0]  op_rd;
   logic        op_illegal;
`ifdef ALU_ISSUE_STATS_EN
   logic [31:0] issued_count;
   logic [15:0] illegal_count;
   int unsigned m_issued;
   int unsigned m_illegal;
`endif

   alu_issue_stage #(.XLEN(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .pc          (pc),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_sel      (op_sel),
      .op_rd       (op_rd),
      .op_illegal  (op_illegal)
`ifdef ALU_ISSUE_STATS_EN
      ,
      .issued_count  (issued_count),
      .illegal_count (illegal_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference decoder: names the RV32I mnemonic first, then derives operands.
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                       input logic [31:0] r1, input logic [31:0] r2);
      exp_t        e;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] immi;
      logic [31:0] immu;
      logic [31:0] sh;
      string       mn;
      opc  = ins[6:0];
      f3   = ins[14:12];
      f7   = ins[31:25];
      immi = {{20{ins[31]}}, ins[31:20]};
      immu = ins & 32'hFFFF_F000;
      sh   = {27'd0, ins[24:20]};
      mn   = "";
      e    = '{sel: 4'd15, a: 32'd0, b: 32'd0, rd: 5'd0, ill: 1'b1};
      if (opc == 7'h33) begin
         if (f7 == 7'h00) begin
            case (f3)
               3'd0: mn = "ADD";  3'd1: mn = "SLL"; 3'd2: mn = "SLT"; 3'd3: mn = "SLTU";
               3'd4: mn = "XOR";  3'd5: mn = "SRL"; 3'd6: mn = "OR";  default: mn = "AND";
            endcase
         end else if (f7 == 7'h20 && f3 == 3'd0) mn = "SUB";
         else if (f7 == 7'h20 && f3 == 3'd5) mn = "SRA";
         e.a = r1; e.b = r2;
      end else if (opc == 7'h13) begin
         e.a = r1; e.b = immi;
         case (f3)
            3'd0: mn = "ADD"; 3'd2: mn = "SLT"; 3'd3: mn = "SLTU"; 3'd4: mn = "XOR";
            3'd6: mn = "OR";  3'd7: mn = "AND";
            3'd1: begin e.b = sh; if (f7 == 7'h00) mn = "SLL"; end
            default: begin
               e.b = sh;
               if (f7 == 7'h00) mn = "SRL";
               else if (f7 == 7'h20) mn = "SRA";
            end
         endcase
      end else if (opc == 7'h37) begin
         mn = "ADD"; e.a = 32'd0; e.b = immu;
      end else if (opc == 7'h17) begin
         mn = "ADD"; e.a = p; e.b = immu;
      end
      case (mn)
         "ADD":  e.sel = 4'd0;  "SUB":  e.sel = 4'd1;  "AND": e.sel = 4'd2;
         "OR":   e.sel = 4'd3;  "XOR":  e.sel = 4'd4;  "SLT": e.sel = 4'd5;
         "SLTU": e.sel = 4'd6;  "SLL":  e.sel = 4'd7;  "SRL": e.sel = 4'd8;
         "SRA":  e.sel = 4'd9;  default: e.sel = 4'd15;
      endcase
      if (mn == "") begin
         e = '{sel: 4'd15, a: 32'd0, b: 32'd0, rd: 5'd0, ill: 1'b1};
      end else begin
         e.rd  = ins[11:7];
         e.ill = 1'b0;
      end
      return e;
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".op_valid"}, 32'(op_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         chk({tag, ".op_sel"},     32'(op_sel),     32'(q[0].sel));
         chk({tag, ".op_a"},       op_a,            q[0].a);
         chk({tag, ".op_b"},       op_b,            q[0].b);
         chk({tag, ".op_rd"},      32'(op_rd),      32'(q[0].rd));
         chk({tag, ".op_illegal"}, 32'(op_illegal), 32'(q[0].ill));
      end
`ifdef ALU_ISSUE_STATS_EN
      chk({tag, ".issued_count"},  issued_count,         m_issued);
      chk({tag, ".illegal_count"}, 32'(illegal_count),   m_illegal);
`endif
   endtask

   // Called at posedge+1: drive inputs, run one clock, update the FIFO model,
   // then check outputs at the following posedge+1.
   task automatic step(input string tag, input logic v, input logic [31:0] ins,
                       input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2,
                       input logic ordy, input logic fl);
      exp_t e;
      logic acc;
      logic xf;
      instr_valid = v; instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
      op_ready = ordy; flush = fl;
      chk({tag, ".instr_ready"}, 32'(instr_ready), 32'(q.size() < 2));
      e   = ref_decode(ins, p, r1, r2);
      acc = v && (q.size() < 2);
      xf  = (q.size() > 0) && ordy;
      @(posedge clk);
`ifdef ALU_ISSUE_STATS_EN
      if (xf) begin
         m_issued++;
         if (q[0].ill && m_illegal < 32'hFFFF) m_illegal++;
      end
`endif
      if (fl) begin
         q.delete();
      end else begin
         if (xf) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
      #1;
      check_outputs(tag);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int unsigned k;
      w = $urandom;
      k = $urandom_range(0, 5);
      case (k)
         0: begin w[6:0] = 7'h33; if ($urandom_range(0, 3) != 0) w[31:25] = 7'h00; end
         1: begin w[6:0] = 7'h13;
                  case ($urandom_range(0, 2))
                     0: w[31:25] = 7'h00;
                     1: w[31:25] = 7'h20;
                     default: ;
                  endcase
            end
         2: w[6:0] = 7'h37;
         3: w[6:0] = 7'h17;
         4: ;
         default: begin w[6:0] = 7'h33; w[31:25] = 7'h20; end
      endcase
      return w;
   endfunction

   initial begin
      reset = 1'b0; flush = 1'b0; instr_valid = 1'b0; op_ready = 1'b0;
      instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
`ifdef ALU_ISSUE_STATS_EN
      m_issued = 0; m_illegal = 0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("reset.op_valid",    32'(op_valid),    32'd0);
      chk("reset.op_sel",      32'(op_sel),      32'd10);
      chk("reset.op_a",        op_a,             32'd0);
      chk("reset.op_b",        op_b,             32'd0);
      chk("reset.op_rd",       32'(op_rd),       32'd0);
      chk("reset.op_illegal",  32'(op_illegal),  32'd0);
      chk("reset.instr_ready", 32'(instr_ready), 32'd1);
      #3 reset = 1'b1;
      @(posedge clk);
      #1;

      // Directed decode cases, streaming at full throughput.
      step("add",   1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd3, 1'b1, 1'b0);
      chk("add.sel_const", 32'(op_sel), 32'd0);
      chk("add.a_const",   op_a,        32'd5);
      chk("add.b_const",   op_b,        32'd3);
      chk("add.rd_const",  32'(op_rd),  32'd3);
      step("srai",  1'b1, 32'h40435293, 32'h0, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
      chk("srai.sel_const", 32'(op_sel), 32'd9);
      chk("srai.b_const",   op_b,        32'd4);
      chk("srai.rd_const",  32'(op_rd),  32'd5);
      step("auipc", 1'b1, 32'h12345097, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("auipc.a_const", op_a, 32'h100);
      chk("auipc.b_const", op_b, 32'h1234_5000);
      step("jal",   1'b1, 32'h0000006F, 32'h0, 32'h11, 32'h22, 1'b1, 1'b0);
      chk("jal.sel_const", 32'(op_sel),     32'd15);
      chk("jal.ill_const", 32'(op_illegal), 32'd1);
      step("mul",   1'b1, 32'h022081B3, 32'h0, 32'h11, 32'h22, 1'b1, 1'b0);
      chk("mul.sel_const", 32'(op_sel), 32'd15);
      chk("mul.rd_const",  32'(op_rd),  32'd0);
      step("drain", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef ALU_ISSUE_STATS_EN
      chk("stats.illegal_two", 32'(illegal_count), 32'd2);
      chk("stats.issued_five", issued_count,       32'd5);
`endif

      // Backpressure: three back-to-back, third must wait upstream.
      step("bp1", 1'b1, 32'h00310233, 32'h0, 32'd1, 32'd2, 1'b0, 1'b0);
      step("bp2", 1'b1, 32'h403100B3, 32'h0, 32'd9, 32'd4, 1'b0, 1'b0);
      chk("bp2.ready_low", 32'(instr_ready), 32'd0);
      step("bp3", 1'b1, 32'h0FF3F393, 32'h0, 32'd7, 32'd0, 1'b0, 1'b0);
      step("bp4", 1'b1, 32'h0FF3F393, 32'h0, 32'd7, 32'd0, 1'b1, 1'b0);
      step("bp5", 1'b1, 32'h0FF3F393, 32'h0, 32'd7, 32'd0, 1'b1, 1'b0);
      step("bp6", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset with skid full and output stalled.
      step("rs1", 1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd1, 1'b0, 1'b0);
      step("rs2", 1'b1, 32'h00A00093, 32'h0, 32'd2, 32'd0, 1'b0, 1'b0);
      chk("rs2.ready_low", 32'(instr_ready), 32'd0);
      instr_valid = 1'b0;
      #3 reset = 1'b0;
      #1;
      q.delete();
`ifdef ALU_ISSUE_STATS_EN
      m_issued = 0; m_illegal = 0;
`endif
      chk("rst_mid.op_valid",    32'(op_valid),    32'd0);
      chk("rst_mid.instr_ready", 32'(instr_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("rst_hold.instr_ready", 32'(instr_ready), 32'd1);
      #3 reset = 1'b1;
      @(posedge clk);
      #1;

      // Flush with skid full, then flush racing a real accept.
      step("fl1", 1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd1, 1'b0, 1'b0);
      step("fl2", 1'b1, 32'h00A00093, 32'h0, 32'd2, 32'd0, 1'b0, 1'b0);
      step("fl3", 1'b1, 32'h00B00093, 32'h0, 32'd3, 32'd0, 1'b0, 1'b1);
      chk("fl3.ready_high", 32'(instr_ready), 32'd1);
      step("fl4", 1'b1, 32'h002081B3, 32'h0, 32'd4, 32'd4, 1'b0, 1'b0);
      step("fl5", 1'b1, 32'h40208133, 32'h0, 32'd5, 32'd5, 1'b0, 1'b1);
      step("fl6", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("fl6.not_issued", 32'(op_valid), 32'd0);

      // Randomized traffic against the FIFO reference.
      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom_range(0, 9) < 7), rand_instr(), $urandom, $urandom, $urandom,
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
      end
      for (int i = 0; i < 3; i++) begin
         step("final", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the ALU operand/select interface.
- Accepts RV32I instructions plus register-file read data over a valid/ready handshake, and decodes ALU-class instructions into alu_sel, operand A and operand B.
- Presents the result through a registered output stage with a one-entry skid buffer. Sits between the register-file read stage and the ALU.

Parameters:
- XLEN, 32, datapath width of operands and instruction.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all held operations.
- instr_valid  in  1  upstream holds a valid instruction.
- instr_ready  out  1  stage can accept an instruction this cycle.
- instr  in  XLEN  RV32I instruction word.
- pc  in  XLEN  address of instr.
- rs1_data  in  XLEN  register-file value for instr[19:15].
- rs2_data  in  XLEN  register-file value for instr[24:20].
- op_valid  out  1  an ALU operation is presented.
- op_ready  in  1  ALU/execute consumes the operation this cycle.
- op_a  out  XLEN  ALU operand a.
- op_b  out  XLEN  ALU operand b.
- op_sel  out  4  ALU select.
- op_rd  out  5  destination register.
- op_illegal  out  1  instruction was not ALU-class or was malformed.

Behaviour:
- ALU select encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, NOP=10, INVALID=15.
- Reset (reset=0, asynchronous) clears all state:
  - op_valid=0, op_sel=NOP, op_a=op_b=0, op_rd=0, op_illegal=0.
  - Skid buffer empty, so instr_ready=1.
- Handshakes:
  - Accept occurs when instr_valid && instr_ready.
  - Transfer occurs when op_valid && op_ready.
- instr_ready = !skid_valid, driven from a register with no combinational path from op_ready.
- Latency and throughput: an accepted instruction appears on op_* one cycle later; throughput is 1/cycle while op_ready=1.
- On accept:
  - If the output register is empty or transferring this cycle, the decoded op loads into the output register.
  - Otherwise the decoded op loads into the skid buffer.
- On transfer with the skid buffer full, skid contents move to the output register and the skid buffer empties.
- op_* remain stable while op_valid && !op_ready.
- Ordering is strictly FIFO. No op is dropped or duplicated.
- flush=1 clears op_valid and the skid buffer next edge. An accept in the same cycle is discarded. flush has priority over all other events.
- Decode for OP (opcode 0110011): a=rs1_data, b=rs2_data.
  - funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: funct3 000 SUB, 101 SRA. Any other funct3 is illegal.
  - Any other funct7 is illegal.
- Decode for OP-IMM (opcode 0010011): a=rs1_data, b=sign-extended instr[31:20].
  - funct3 mapping is as for OP; funct3 000 is ADD.
  - Shifts (001, 101): b={27'b0, instr[24:20]}.
  - Shifts require instr[31:25]=0000000, except SRAI, which requires 0100000. Otherwise illegal.
- LUI (0110111): ADD, a=0, b={instr[31:12],12'b0}.
- AUIPC (0010111): ADD, a=pc, b={instr[31:12],12'b0}.
- For legal ops, op_rd=instr[11:7].
- Illegal, or any other opcode:
  - op_sel=INVALID, op_illegal=1, op_a=op_b=0, op_rd=0.
  - The op is still issued with op_valid=1.
- Reset mid-operation (skid full, output stalled) empties both registers immediately. instr_ready returns to 1 while reset is low.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- Defined:
  - Adds outputs issued_count (32-bit, increments on each transfer) and illegal_count (16-bit, increments on each transfer with op_illegal=1, saturates at 0xFFFF).
  - Both counters reset to 0 on reset. flush does not clear them.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- ADD: instr=0x002081B3 (add x3,x1,x2), rs1_data=5, rs2_data=3, op_ready=1 -> next cycle op_valid=1, op_sel=ADD(0), op_a=5, op_b=3, op_rd=3, op_illegal=0.
- SRAI: instr=0x40435293 (srai x5,x6,4), rs1_data=0x80000000 -> op_sel=SRA(9), op_a=0x80000000, op_b=4, op_rd=5.
- AUIPC: instr=0x12345097, pc=0x100 -> op_sel=ADD, op_a=0x100, op_b=0x12345000, op_rd=1.
- Illegal:
  - instr=0x0000006F (jal) -> op_sel=INVALID(15), op_illegal=1, op_rd=0.
  - instr=0x022081B3 (mul) -> same response.
  - With ALU_ISSUE_STATS_EN: illegal_count=2 after both transfer.
- Backpressure: op_ready=0, three back-to-back valid instructions -> first held on op_*, second in skid, instr_ready=0 from the cycle after the second accept, third held upstream. Raise op_ready -> all three issued in order, one per cycle, none lost.
- Reset/flush: with skid full and op_valid=1, pulse reset low mid-cycle -> op_valid=0 and instr_ready=1 immediately. Repeat using flush=1 -> same result at the next edge, and the concurrent instruction is not issued.
